uart_reg_bridge: RTL



---
 rtl/uart_reg_bridge.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/uart_reg_bridge.sv
// Wishbone classic slave to UART reg-bus bridge: registers every reg-bus output,
// holds reg_cs until reg_ack, and bounds each request with a timeout.
module uart_reg_bridge #(
  parameter int AW      = 11,
  parameter int DW      = 32,
  parameter int TMO_CNT = 255
) (
  input  logic            app_clk,
  input  logic            reset,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic [AW-1:0]   wbs_adr_i,
  input  logic            wbs_we_i,
  input  logic [DW-1:0]   wbs_dat_i,
  input  logic [DW/8-1:0] wbs_sel_i,
  output logic [DW-1:0]   wbs_dat_o,
  output logic            wbs_ack_o,
  output logic            wbs_err_o,
  output logic            reg_cs,
  output logic            reg_wr,
  output logic [AW-1:0]   reg_addr,
  output logic [DW-1:0]   reg_wdata,
  output logic [DW/8-1:0] reg_be,
  input  logic [DW-1:0]   reg_rdata,
  input  logic            reg_ack,
  output logic            tmo_event
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TMO_CNT - 1);

  state_t          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            reg_cs_q, reg_cs_d;
  logic            reg_wr_q, reg_wr_d;
  logic [AW-1:0]   reg_addr_q, reg_addr_d;
  logic [DW-1:0]   reg_wdata_q, reg_wdata_d;
  logic [DW/8-1:0] reg_be_q, reg_be_d;
  logic [DW-1:0]   wbs_dat_q, wbs_dat_d;
  logic            wbs_ack_q, wbs_ack_d;
  logic            wbs_err_q, wbs_err_d;
  logic            tmo_q, tmo_d;

  // Next-state and next-output logic; abort beats ack, ack beats timeout.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    reg_cs_d    = reg_cs_q;
    reg_wr_d    = reg_wr_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_be_d    = reg_be_q;
    wbs_dat_d   = wbs_dat_q;
    wbs_ack_d   = 1'b0;
    wbs_err_d   = 1'b0;
    tmo_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          reg_addr_d  = wbs_adr_i;
          reg_wr_d    = wbs_we_i;
          reg_wdata_d = wbs_dat_i;
          reg_be_d    = wbs_sel_i;
          reg_cs_d    = 1'b1;
          cnt_d       = 16'd0;
          state_d     = REQ;
        end else begin
          reg_cs_d = 1'b0;
          state_d  = IDLE;
        end
      end
      REQ: begin
        if (!wbs_cyc_i) begin
          reg_cs_d = 1'b0;
          state_d  = IDLE;
        end else if (reg_ack) begin
          reg_cs_d  = 1'b0;
          wbs_ack_d = 1'b1;
          wbs_dat_d = reg_wr_q ? {DW{1'b0}} : reg_rdata;
          state_d   = RESP;
        end else if (cnt_q == TMO_LAST) begin
          reg_cs_d  = 1'b0;
          wbs_err_d = 1'b1;
          tmo_d     = 1'b1;
          wbs_dat_d = {DW{1'b0}};
          state_d   = RESP;
        end else begin
          cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        reg_cs_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge app_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 16'd0;
      reg_cs_q    <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_addr_q  <= {AW{1'b0}};
      reg_wdata_q <= {DW{1'b0}};
      reg_be_q    <= {(DW/8){1'b0}};
      wbs_dat_q   <= {DW{1'b0}};
      wbs_ack_q   <= 1'b0;
      wbs_err_q   <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reg_cs_q    <= reg_cs_d;
      reg_wr_q    <= reg_wr_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_be_q    <= reg_be_d;
      wbs_dat_q   <= wbs_dat_d;
      wbs_ack_q   <= wbs_ack_d;
      wbs_err_q   <= wbs_err_d;
      tmo_q       <= tmo_d;
    end
  end

  assign reg_cs    = reg_cs_q;
  assign reg_wr    = reg_wr_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_be    = reg_be_q;
  assign wbs_dat_o = wbs_dat_q;
  assign wbs_ack_o = wbs_ack_q;
  assign wbs_err_o = wbs_err_q;
  assign tmo_event = tmo_q;

endmodule
